// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: Gray/binary conversion and the default depth.
// The conversions work on zero-extended 32-bit values, so any pointer width up to 32 bits can use them.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; the zero-extended upper bits leave the result unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty/level tracking and a
// first-word-fall-through output register with a valid/ready handshake.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  i_r_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_r_ready,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH:0]   o_rptr,
  output logic                  o_r_valid,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic                  o_r_empty,
  output logic                  o_r_aempty,
  output logic [ADDR_WIDTH:0]   o_r_level,
  output logic                  o_ptr_err
);

  localparam int PW        = ADDR_WIDTH + 1;
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  err_q, err_d;

  logic [PW-1:0] wbin;
  logic [PW-1:0] level_raw;
  logic          mem_empty;
  logic          bad;
  logic          fetch;

  // Fetch is also gated by reset so no read strobe escapes while the block is held.
  always_comb begin
    wbin      = PW'(gray2bin(32'(rq2_wptr)));
    level_raw = wbin - rbin_q;
    mem_empty = (PW'(bin2gray(32'(rbin_q))) == rq2_wptr);
    bad       = (level_raw > PW'(MEM_DEPTH));
    fetch     = ~mem_empty & ~bad & (~valid_q | i_r_ready) & i_rst_n;
  end

  always_comb begin
    rbin_d  = rbin_q + PW'(fetch);
    rptr_d  = PW'(bin2gray(32'(rbin_d)));
    valid_d = valid_q;
    data_d  = data_q;
    if (fetch) begin
      valid_d = 1'b1;
      data_d  = i_rd_data;
    end else if (valid_q && i_r_ready) begin
      valid_d = 1'b0;
    end
    level_d = level_raw + PW'(valid_q);
    err_d   = err_q | bad;
  end

  always_ff @(posedge i_r_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rbin_q  <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    o_rd_addr  = rbin_q[ADDR_WIDTH-1:0];
    o_rd_en    = fetch;
    o_rptr     = rptr_q;
    o_r_valid  = valid_q;
    o_r_data   = data_q;
    o_r_empty  = ~valid_q;
    o_r_aempty = (level_q <= PW'(AEMPTY_THRESH));
    o_r_level  = level_q;
    o_ptr_err  = err_q;
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus a randomized phase,
// checked against a FIFO-order reference model built on word counts and a queue.
module tb_fifo_rd_ctrl;

  logic       i_r_clk;
  logic       i_rst_n;
  logic [5:0] rq2_wptr;
  logic [7:0] i_rd_data;
  logic       i_r_ready;
  logic [4:0] o_rd_addr;
  logic       o_rd_en;
  logic [5:0] o_rptr;
  logic       o_r_valid;
  logic [7:0] o_r_data;
  logic       o_r_empty;
  logic       o_r_aempty;
  logic [5:0] o_r_level;
  logic       o_ptr_err;

  logic [7:0] mem [32];

  int vectors     = 0;
  int miscompares = 0;

  int         wcnt;
  int         rd_cnt;
  bit         exp_valid;
  logic [7:0] exp_data;
  int         exp_level;
  bit         exp_err;
  logic [7:0] exp_q [$];

  fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .AEMPTY_THRESH(2)) dut (
    .i_r_clk   (i_r_clk),
    .i_rst_n   (i_rst_n),
    .rq2_wptr  (rq2_wptr),
    .i_rd_data (i_rd_data),
    .i_r_ready (i_r_ready),
    .o_rd_addr (o_rd_addr),
    .o_rd_en   (o_rd_en),
    .o_rptr    (o_rptr),
    .o_r_valid (o_r_valid),
    .o_r_data  (o_r_data),
    .o_r_empty (o_r_empty),
    .o_r_aempty(o_r_aempty),
    .o_r_level (o_r_level),
    .o_ptr_err (o_ptr_err)
  );

  assign i_rd_data = mem[o_rd_addr];

  initial i_r_clk = 1'b0;
  always #5 i_r_clk = ~i_r_clk;

  function automatic logic [5:0] gray6(input int n);
    logic [5:0] b;
    b = 6'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_wptr(input int n);
    wcnt     = n & 63;
    rq2_wptr = gray6(wcnt);
  endtask

  task automatic push_word(input logic [7:0] val);
    mem[wcnt % 32] = val;
    exp_q.push_back(val);
    set_wptr(wcnt + 1);
  endtask

  task automatic model_reset();
    rd_cnt    = 0;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    exp_level = 0;
    exp_err   = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_output();
    check("rptr",   32'(o_rptr),     32'(gray6(rd_cnt)));
    check("rdaddr", 32'(o_rd_addr),  32'(rd_cnt % 32));
    check("valid",  32'(o_r_valid),  32'(exp_valid));
    check("data",   32'(o_r_data),   32'(exp_data));
    check("empty",  32'(o_r_empty),  32'(!exp_valid));
    check("aempty", 32'(o_r_aempty), 32'(exp_level <= 2));
    check("level",  32'(o_r_level),  32'(exp_level));
    check("err",    32'(o_ptr_err),  32'(exp_err));
  endtask

  // One clock of stimulus: predict the fetch from word counts, then advance the model.
  task automatic apply_stimulus(input logic ready);
    int avail;
    bit bad;
    bit fetch;
    i_r_ready = ready;
    #1;
    avail = (wcnt - rd_cnt) & 63;
    bad   = (avail > 32);
    fetch = (avail != 0) && !bad && (!exp_valid || ready);
    check("rd_en", 32'(o_rd_en), 32'(fetch));
    if (fetch) check("fetch_addr", 32'(o_rd_addr), 32'(rd_cnt % 32));
    @(posedge i_r_clk);
    exp_level = avail + int'(exp_valid);
    if (bad) exp_err = 1'b1;
    if (fetch) begin
      if (exp_q.size() > 0) exp_data = exp_q.pop_front();
      exp_valid = 1'b1;
      rd_cnt    = (rd_cnt + 1) & 63;
    end else if (exp_valid && ready) begin
      exp_valid = 1'b0;
    end
    @(negedge i_r_clk);
    check_output();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    model_reset();
    set_wptr(0);
    @(negedge i_r_clk);
    i_rst_n = 1'b1;
    check_output();
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_r_ready = 1'b0;
    rq2_wptr  = 6'b000011;
    foreach (mem[i]) mem[i] = 8'h00;
    model_reset();
    wcnt = 3;

    // Reset with a non-empty write pointer must not raise the read strobe.
    #3;
    check("rst_rd_en", 32'(o_rd_en), 32'd0);
    check_output();
    @(negedge i_r_clk);
    set_wptr(0);
    i_rst_n = 1'b1;
    check_output();
    apply_stimulus(1'b0);

    $display("[TB] single word");
    push_word(8'hA5);
    apply_stimulus(1'b0);
    check("single_data", 32'(o_r_data), 32'h0000_00A5);
    check("single_rptr", 32'(o_rptr), 32'h0000_0001);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    check("single_pop", 32'(o_r_valid), 32'd0);
    apply_stimulus(1'b0);

    $display("[TB] full drain");
    do_reset();
    for (int i = 0; i < 32; i++) push_word(8'(i));
    check("full_wptr", 32'(rq2_wptr), 32'h0000_0030);
    for (int i = 0; i < 34; i++) apply_stimulus(1'b1);
    check("drain_rptr", 32'(o_rptr), 32'h0000_0030);

    $display("[TB] wrap");
    for (int i = 0; i < 28; i++) push_word(8'($urandom));
    for (int i = 0; i < 30; i++) apply_stimulus(1'b1);
    check("pre_wrap_cnt", 32'(o_rd_addr), 32'd28);
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1);
    check("wrap_rptr", 32'(o_rptr), 32'h0000_0006);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++)
          if (((wcnt - rd_cnt) & 63) < 32) push_word(8'($urandom));
      end
      apply_stimulus(1'($urandom_range(0, 1)));
    end

    $display("[TB] pointer error");
    do_reset();
    set_wptr(40);
    apply_stimulus(1'b1);
    check("err_set", 32'(o_ptr_err), 32'd1);
    apply_stimulus(1'b1);
    set_wptr(0);
    apply_stimulus(1'b1);
    check("err_sticky", 32'(o_ptr_err), 32'd1);

    $display("[TB] mid-stream reset");
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h50 + i));
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1);
    check("mid_valid", 32'(o_r_valid), 32'd1);
    check("mid_addr", 32'(o_rd_addr), 32'd7);
    i_r_ready = 1'b0;
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_rd_en", 32'(o_rd_en), 32'd0);
    check_output();
    @(negedge i_r_clk);
    @(negedge i_r_clk);
    set_wptr(0);
    i_rst_n = 1'b1;
    check_output();
    push_word(8'h3C);
    apply_stimulus(1'b0);
    check("resume_data", 32'(o_r_data), 32'h0000_003C);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
